// File: rtl/fpu_utils_lzc_norm_pipe.sv
// Two-stage leading/trailing-zero counter with a fused normalization shifter.
// Stage 1 counts zeros and registers the operand; stage 2 clamps the count and shifts.
module fpu_utils_lzc_norm_pipe #(
  parameter int WIDTH = 52,
  parameter int CNT_W = $clog2(WIDTH),
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_trailing_i,
  input  logic [CNT_W-1:0] in_max_shift_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] out_cnt_o,
  output logic [CNT_W-1:0] out_zc_o,
  output logic             out_empty_o,
  output logic             out_clamped_o,
  output logic [TAG_W-1:0] out_tag_o
);

  localparam int P = 1 << CNT_W;

  // Leading-zero count over a power-of-two vector; padding leaves sit at the LSB end
  // and are zero, so they never win against a real set bit.
  function automatic logic [CNT_W-1:0] lzc_tree(input logic [P-1:0] v);
    logic [P-1:0]            nz;
    logic [P-1:0][CNT_W-1:0] cnt;
    nz  = '0;
    cnt = '0;
    for (int i = 0; i < P; i++) nz[i] = v[P-1-i];
    for (int l = 1; l <= CNT_W; l++) begin
      for (int n = 0; n < (P >> l); n++) begin
        if (nz[2*n]) begin
          cnt[n] = cnt[2*n];
        end else begin
          cnt[n]      = cnt[2*n+1];
          cnt[n][l-1] = 1'b1;
        end
        nz[n] = nz[2*n] | nz[2*n+1];
      end
    end
    return nz[0] ? cnt[0] : '0;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_shift(input logic [CNT_W-1:0] zc,
                                                   input logic [CNT_W-1:0] mx);
    return (zc > mx) ? mx : zc;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic             s1_mode_q, s1_mode_d;
  logic [CNT_W-1:0] s1_max_q, s1_max_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [CNT_W-1:0] s1_zc_q, s1_zc_d;
  logic             s1_empty_q, s1_empty_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic [CNT_W-1:0] s2_cnt_q, s2_cnt_d;
  logic [CNT_W-1:0] s2_zc_q, s2_zc_d;
  logic             s2_empty_q, s2_empty_d;
  logic             s2_clamped_q, s2_clamped_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic             s1_adv, in_fire, s2_load;
  logic [P-1:0]     lzc_in;
  logic [WIDTH-1:0] rev_data;
  logic [CNT_W-1:0] sh;

  assign s1_adv      = ~s2_valid_q | out_ready_i;
  assign in_ready_o  = ~s1_valid_q | s1_adv;
  assign in_fire     = in_valid_i & in_ready_o & ~flush_i;
  assign s2_load     = s1_valid_q & s1_adv & ~flush_i;

  // ---- stage 1: zero count ----
  always_comb begin
    rev_data = '0;
    for (int i = 0; i < WIDTH; i++) rev_data[i] = in_data_i[WIDTH-1-i];
    lzc_in = '0;
    lzc_in[P-1 -: WIDTH] = in_trailing_i ? rev_data : in_data_i;

    s1_valid_d = s1_valid_q;
    if (flush_i)         s1_valid_d = 1'b0;
    else if (in_ready_o) s1_valid_d = in_valid_i;

    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_max_d   = s1_max_q;
    s1_tag_d   = s1_tag_q;
    s1_zc_d    = s1_zc_q;
    s1_empty_d = s1_empty_q;
    if (in_fire) begin
      s1_data_d  = in_data_i;
      s1_mode_d  = in_trailing_i;
      s1_max_d   = in_max_shift_i;
      s1_tag_d   = in_tag_i;
      s1_zc_d    = lzc_tree(lzc_in);
      s1_empty_d = ~|in_data_i;
    end
  end

  // ---- stage 2: clamp and shift ----
  always_comb begin
    sh = s1_empty_q ? '0 : clamp_shift(s1_zc_q, s1_max_q);

    s2_valid_d = s2_valid_q;
    if (flush_i)     s2_valid_d = 1'b0;
    else if (s1_adv) s2_valid_d = s1_valid_q;

    s2_data_d    = s2_data_q;
    s2_cnt_d     = s2_cnt_q;
    s2_zc_d      = s2_zc_q;
    s2_empty_d   = s2_empty_q;
    s2_clamped_d = s2_clamped_q;
    s2_tag_d     = s2_tag_q;
    if (s2_load) begin
      s2_data_d    = s1_mode_q ? (s1_data_q >> sh) : (s1_data_q << sh);
      s2_cnt_d     = sh;
      s2_zc_d      = s1_zc_q;
      s2_empty_d   = s1_empty_q;
      s2_clamped_d = (s1_zc_q > s1_max_q) & ~s1_empty_q;
      s2_tag_d     = s1_tag_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_mode_q    <= 1'b0;
      s1_max_q     <= '0;
      s1_tag_q     <= '0;
      s1_zc_q      <= '0;
      s1_empty_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_cnt_q     <= '0;
      s2_zc_q      <= '0;
      s2_empty_q   <= 1'b0;
      s2_clamped_q <= 1'b0;
      s2_tag_q     <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_mode_q    <= s1_mode_d;
      s1_max_q     <= s1_max_d;
      s1_tag_q     <= s1_tag_d;
      s1_zc_q      <= s1_zc_d;
      s1_empty_q   <= s1_empty_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_cnt_q     <= s2_cnt_d;
      s2_zc_q      <= s2_zc_d;
      s2_empty_q   <= s2_empty_d;
      s2_clamped_q <= s2_clamped_d;
      s2_tag_q     <= s2_tag_d;
    end
  end

  assign out_valid_o   = s2_valid_q;
  assign out_data_o    = s2_data_q;
  assign out_cnt_o     = s2_cnt_q;
  assign out_zc_o      = s2_zc_q;
  assign out_empty_o   = s2_empty_q;
  assign out_clamped_o = s2_clamped_q;
  assign out_tag_o     = s2_tag_q;

endmodule

// File: tb/tb_fpu_utils_lzc_norm_pipe.sv
// Scoreboard bench for fpu_utils_lzc_norm_pipe at WIDTH=8 with hand-computed vectors.
module tb_fpu_utils_lzc_norm_pipe;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] cnt;
    logic [2:0] zc;
    logic       empty;
    logic       clamped;
    logic [3:0] tag;
  } res_t;

  typedef struct packed {
    logic       mode;
    logic [7:0] d;
    logic [2:0] mx;
    logic [3:0] tag;
    res_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       flush_i = 1'b0;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [7:0] in_data_i = '0;
  logic       in_trailing_i = 1'b0;
  logic [2:0] in_max_shift_i = '0;
  logic [3:0] in_tag_i = '0;
  logic       out_valid_o;
  logic       out_ready_i = 1'b1;
  logic [7:0] out_data_o;
  logic [2:0] out_cnt_o;
  logic [2:0] out_zc_o;
  logic       out_empty_o;
  logic       out_clamped_o;
  logic [3:0] out_tag_o;

  fpu_utils_lzc_norm_pipe #(.WIDTH(8), .CNT_W(3), .TAG_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_trailing_i(in_trailing_i), .in_max_shift_i(in_max_shift_i), .in_tag_i(in_tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_cnt_o(out_cnt_o), .out_zc_o(out_zc_o), .out_empty_o(out_empty_o),
    .out_clamped_o(out_clamped_o), .out_tag_o(out_tag_o)
  );

  always #5 clk = ~clk;

  res_t cur;
  assign cur = {out_data_o, out_cnt_o, out_zc_o, out_empty_o, out_clamped_o, out_tag_o};

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  res_t sb[$];
  int   pop_cyc[$];
  vec_t v[12];
  bit   held = 1'b0;
  res_t snap = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input bit m, input logic [7:0] d, input logic [2:0] mx,
                              input logic [3:0] tg, input logic [7:0] ed, input logic [2:0] ec,
                              input logic [2:0] ez, input bit ee, input bit ecl);
    vec_t r;
    r.mode = m; r.d = d; r.mx = mx; r.tag = tg;
    r.exp.data = ed; r.exp.cnt = ec; r.exp.zc = ez;
    r.exp.empty = ee; r.exp.clamped = ecl; r.exp.tag = tg;
    return r;
  endfunction

  // Monitor: pops the scoreboard on every output transfer, checks hold stability.
  always @(negedge clk) begin
    res_t e;
    if (rst_ni && out_valid_o && held)
      chk("hold_stable", cur == snap, cur, snap);
    if (rst_ni && out_valid_o && out_ready_i && !flush_i) begin
      chk("unexpected_out", sb.size() != 0, cur, 0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("result", cur == e, cur, e);
        pop_cyc.push_back(cyc);
      end
    end
    held = rst_ni & out_valid_o & ~out_ready_i & ~flush_i;
    snap = cur;
  end

  task automatic drive(input vec_t x);
    in_valid_i = 1'b1; in_data_i = x.d; in_trailing_i = x.mode;
    in_max_shift_i = x.mx; in_tag_i = x.tag;
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
  endtask

  task automatic offer(input vec_t x, output int tries);
    bit acc;
    acc = 1'b0;
    tries = 0;
    drive(x);
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = in_ready_o;
      @(posedge clk);
      if (acc) sb.push_back(x.exp);
      tries++;
      #1;
    end
    if (!acc) chk("accept_timeout", acc, tries, 50);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size() == 0, sb.size(), 0);
  endtask

  initial begin
    int t, acc_cnt, k, base;
    bit acc;
    v[0]  = mk(0, 8'h13, 3'd7, 4'h5, 8'h98, 3'd3, 3'd3, 0, 0);
    v[1]  = mk(0, 8'h01, 3'd4, 4'h1, 8'h10, 3'd4, 3'd7, 0, 1);
    v[2]  = mk(1, 8'h80, 3'd7, 4'h2, 8'h01, 3'd7, 3'd7, 0, 0);
    v[3]  = mk(0, 8'h00, 3'd7, 4'h3, 8'h00, 3'd0, 3'd0, 1, 0);
    v[4]  = mk(1, 8'h00, 3'd0, 4'h4, 8'h00, 3'd0, 3'd0, 1, 0);
    v[5]  = mk(1, 8'h28, 3'd2, 4'h6, 8'h0A, 3'd2, 3'd3, 0, 1);
    v[6]  = mk(0, 8'h80, 3'd0, 4'h7, 8'h80, 3'd0, 3'd0, 0, 0);
    v[7]  = mk(1, 8'h01, 3'd0, 4'h8, 8'h01, 3'd0, 3'd0, 0, 0);
    v[8]  = mk(0, 8'h40, 3'd0, 4'h9, 8'h40, 3'd0, 3'd1, 0, 1);
    v[9]  = mk(1, 8'hF0, 3'd7, 4'hA, 8'h0F, 3'd4, 3'd4, 0, 0);
    v[10] = mk(0, 8'h0F, 3'd7, 4'hB, 8'hF0, 3'd4, 3'd4, 0, 0);
    v[11] = mk(0, 8'hFF, 3'd3, 4'hC, 8'hFF, 3'd0, 3'd0, 0, 0);

    #1;
    chk("reset_out", cur == '0, cur, 0);
    chk("reset_valid", out_valid_o == 1'b0, out_valid_o, 0);
    chk("reset_ready", in_ready_o == 1'b1, in_ready_o, 1);
    @(negedge clk); @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Latency from an empty pipeline.
    offer(v[0], t);
    idle();
    @(negedge clk);
    chk("lat_cycle1", out_valid_o == 1'b0, out_valid_o, 0);
    @(negedge clk);
    chk("lat_cycle2", out_valid_o == 1'b1, out_valid_o, 1);
    drain();
    @(posedge clk); #1;

    // Back-to-back stream, full throughput.
    base = pop_cyc.size();
    for (int i = 0; i < 6; i++) begin
      offer(v[i], t);
      chk("stream_accept", t == 1, t, 1);
    end
    idle();
    drain();
    chk("stream_consec", pop_cyc.size() == base + 6 && pop_cyc[base+5] - pop_cyc[base] == 5,
        pop_cyc[pop_cyc.size()-1] - pop_cyc[base], 5);
    @(posedge clk); #1;

    // Backpressure: two accepts then in_ready falls.
    out_ready_i = 1'b0;
    acc_cnt = 0;
    k = 6;
    for (int c = 0; c < 3; c++) begin
      drive(v[k]);
      @(negedge clk);
      acc = in_ready_o;
      @(posedge clk);
      if (acc) begin sb.push_back(v[k].exp); acc_cnt++; k++; end
      #1;
    end
    chk("bp_accepts", acc_cnt == 2, acc_cnt, 2);
    chk("bp_ready_low", in_ready_o == 1'b0, in_ready_o, 0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    drain();
    @(posedge clk); #1;

    // Flush with a full pipeline and an offered input.
    out_ready_i = 1'b0;
    offer(v[8], t);
    offer(v[9], t);
    drive(v[10]);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    idle();
    sb.delete();
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("flush_clear", out_valid_o == 1'b0, out_valid_o, 0);
    @(posedge clk); #1;
    offer(v[11], t);
    idle();
    @(negedge clk);
    chk("flush_lat1", out_valid_o == 1'b0, out_valid_o, 0);
    @(negedge clk);
    chk("flush_lat2", out_valid_o == 1'b1, out_valid_o, 1);
    drain();
    @(posedge clk); #1;

    // Flush while the pipeline is empty and ready: offered input is discarded.
    drive(v[10]);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("flush_empty", out_valid_o == 1'b0, out_valid_o, 0);
    end
    @(posedge clk); #1;

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) offer(v[9 + i], t);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_valid", out_valid_o == 1'b0, out_valid_o, 0);
    chk("rst_out", cur == '0, cur, 0);
    chk("rst_ready", in_ready_o == 1'b1, in_ready_o, 1);
    idle();
    sb.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_idle", out_valid_o == 1'b0, out_valid_o, 0);
    end
    @(posedge clk); #1;
    offer(v[5], t);
    offer(v[1], t);
    idle();
    drain();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
